// File: rtl/secret_checker_if.sv
// Tap bundle between the secret accumulator/passthrough block and its checker.
// The master side drives start plus the tapped data; the checker (slave) returns status.
interface secret_checker_if;
  logic         start;
  logic [31:0]  accum_in;
  logic [31:0]  accum_out;
  logic         s1_in;
  logic         s1_out;
  logic [1:0]   s2_in;
  logic [1:0]   s2_out;
  logic [7:0]   s8_in;
  logic [7:0]   s8_out;
  logic [32:0]  s33_in;
  logic [32:0]  s33_out;
  logic [63:0]  s64_in;
  logic [63:0]  s64_out;
  logic [64:0]  s65_in;
  logic [64:0]  s65_out;
  logic [128:0] s129_in;
  logic [128:0] s129_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [15:0]  err_count;
  logic [15:0]  first_err_cycle;
  logic [7:0]   first_err_mask;

  modport master (
    output start, accum_in, accum_out, s1_in, s1_out, s2_in, s2_out, s8_in, s8_out,
           s33_in, s33_out, s64_in, s64_out, s65_in, s65_out, s129_in, s129_out,
    input  busy, done, pass, err_count, first_err_cycle, first_err_mask
  );

  modport slave (
    input  start, accum_in, accum_out, s1_in, s1_out, s2_in, s2_out, s8_in, s8_out,
           s33_in, s33_out, s64_in, s64_out, s65_in, s65_out, s129_in, s129_out,
    output busy, done, pass, err_count, first_err_cycle, first_err_mask
  );
endinterface

// File: rtl/secret_checker.sv
// Checks accumulator arithmetic and passthrough equality every RUN cycle, then reports a verdict.
// Latency: busy the edge after start, CYCLES+1 busy cycles; no backpressure, it observes every cycle.
module secret_checker #(
  parameter int unsigned CYCLES  = 100,
  parameter int unsigned MAX_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  secret_checker_if.slave  bus
);

  localparam logic [15:0] LAST_CYC  = 16'(CYCLES - 1);
  localparam logic [15:0] MAX_ERR_W = 16'(MAX_ERR);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t      state_q;
  logic [31:0] prev_out_q;
  logic [31:0] prev_in_q;
  logic [15:0] cyc_q;
  logic [15:0] err_q;
  logic [15:0] first_cyc_q;
  logic [7:0]  first_mask_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  logic [7:0]  mask_d;
  logic [15:0] err_d;
  logic        stop_d;
  logic        last_d;

  // The accumulator is checked against the previous sample, so its power-up value never matters.
  always_comb begin
    mask_d    = 8'h00;
    mask_d[0] = bus.accum_out != (prev_out_q + prev_in_q);
    mask_d[1] = bus.s1_out   != bus.s1_in;
    mask_d[2] = bus.s2_out   != bus.s2_in;
    mask_d[3] = bus.s8_out   != bus.s8_in;
    mask_d[4] = bus.s33_out  != bus.s33_in;
    mask_d[5] = bus.s64_out  != bus.s64_in;
    mask_d[6] = bus.s65_out  != bus.s65_in;
    mask_d[7] = bus.s129_out != bus.s129_in;
    err_d     = err_q;
    if (mask_d != 8'h00 && err_q != 16'hFFFF) begin
      err_d = err_q + 16'd1;
    end
    stop_d = (MAX_ERR_W != 16'd0) && (mask_d != 8'h00) && (err_d == MAX_ERR_W);
    last_d = (cyc_q == LAST_CYC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_out_q   <= 32'd0;
      prev_in_q    <= 32'd0;
      cyc_q        <= 16'd0;
      err_q        <= 16'd0;
      first_cyc_q  <= 16'd0;
      first_mask_q <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= PRIME;
            busy_q  <= 1'b1;
          end
        end
        PRIME: begin
          prev_out_q <= bus.accum_out;
          prev_in_q  <= bus.accum_in;
          cyc_q      <= 16'd0;
          state_q    <= RUN;
        end
        RUN: begin
          prev_out_q <= bus.accum_out;
          prev_in_q  <= bus.accum_in;
          err_q      <= err_d;
          // err_q is still zero only until the first failing cycle, which keeps the record sticky.
          if (mask_d != 8'h00 && err_q == 16'd0) begin
            first_cyc_q  <= cyc_q;
            first_mask_q <= mask_d;
          end
          cyc_q <= cyc_q + 16'd1;
          if (last_d || stop_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
          end
        end
        DONE: begin
          if (bus.start) begin
            state_q      <= PRIME;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 16'd0;
            first_cyc_q  <= 16'd0;
            first_mask_q <= 8'h00;
            cyc_q        <= 16'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_cycle = first_cyc_q;
  assign bus.first_err_mask  = first_mask_q;

endmodule

// File: tb/tb_secret_checker.sv
// Bench for secret_checker: two instances (no early stop, MAX_ERR=2) share one upstream stimulus.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_secret_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  secret_checker_if ai();
  secret_checker_if bi();

  secret_checker #(.CYCLES(10), .MAX_ERR(0)) dut_a (.clk(clk), .rst(rst), .bus(ai));
  secret_checker #(.CYCLES(10), .MAX_ERR(2)) dut_b (.clk(clk), .rst(rst), .bus(bi));

  assign bi.start    = ai.start;
  assign bi.accum_in = ai.accum_in;   assign bi.accum_out = ai.accum_out;
  assign bi.s1_in    = ai.s1_in;      assign bi.s1_out    = ai.s1_out;
  assign bi.s2_in    = ai.s2_in;      assign bi.s2_out    = ai.s2_out;
  assign bi.s8_in    = ai.s8_in;      assign bi.s8_out    = ai.s8_out;
  assign bi.s33_in   = ai.s33_in;     assign bi.s33_out   = ai.s33_out;
  assign bi.s64_in   = ai.s64_in;     assign bi.s64_out   = ai.s64_out;
  assign bi.s65_in   = ai.s65_in;     assign bi.s65_out   = ai.s65_out;
  assign bi.s129_in  = ai.s129_in;    assign bi.s129_out  = ai.s129_out;

  int total = 0;
  int bad   = 0;
  int busy_a, busy_b;
  bit rand_inc;
  logic [31:0] acc_nxt = 32'h1234_5678;
  logic [7:0]  fmask [0:9];
  logic [31:0] h_out [0:10];
  logic [31:0] h_in  [0:10];
  logic [7:0]  h_pm  [0:10];

  typedef struct {
    int          fcyc;
    int          flen;
    logic [7:0]  fm;
    logic [15:0] ea;  logic [15:0] fca; logic [7:0] fma;
    logic [15:0] eb;  logic [15:0] fcb; logic [7:0] fmb; int bbb;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit b, input logic de, input logic be,
                         input logic pe, input logic [15:0] ee, input logic [15:0] fce,
                         input logic [7:0] fme);
    logic d, bs, p;
    logic [15:0] e, fc;
    logic [7:0] fm;
    if (b) begin
      d = bi.done; bs = bi.busy; p = bi.pass; e = bi.err_count; fc = bi.first_err_cycle; fm = bi.first_err_mask;
    end else begin
      d = ai.done; bs = ai.busy; p = ai.pass; e = ai.err_count; fc = ai.first_err_cycle; fm = ai.first_err_mask;
    end
    chk($sformatf("%s.done", tag),  32'(d),  32'(de));
    chk($sformatf("%s.busy", tag),  32'(bs), 32'(be));
    chk($sformatf("%s.pass", tag),  32'(p),  32'(pe));
    chk($sformatf("%s.err", tag),   32'(e),  32'(ee));
    chk($sformatf("%s.fcyc", tag),  32'(fc), 32'(fce));
    chk($sformatf("%s.fmask", tag), 32'(fm), 32'(fme));
  endtask

  task automatic tick;
    @(negedge clk);
    if (ai.busy) busy_a++;
    if (bi.busy) busy_b++;
  endtask

  function automatic logic [31:0] next_inc();
    return rand_inc ? $urandom : 32'd1;
  endfunction

  // Upstream model: accum_out follows out+in of the previous cycle unless f[0] corrupts it;
  // f[7:1] flip the MSB of the matching passthrough output.
  task automatic drive(input int slot, input logic [7:0] f, input logic [31:0] inc);
    logic [159:0] r;
    ai.accum_in  = inc;
    ai.accum_out = acc_nxt + {31'd0, f[0]};
    acc_nxt      = ai.accum_out + inc;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ai.s1_in  = r[0];      ai.s1_out  = r[0] ^ f[1];
    ai.s2_in  = r[2:1];    ai.s2_out  = r[2:1] ^ {f[2], 1'b0};
    ai.s8_in  = r[10:3];   ai.s8_out  = r[10:3] ^ {f[3], 7'd0};
    ai.s33_in = r[43:11];  ai.s33_out = r[43:11] ^ {f[4], 32'd0};
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ai.s64_in = r[63:0];   ai.s64_out = r[63:0] ^ {f[5], 63'd0};
    ai.s65_in = r[128:64]; ai.s65_out = r[128:64] ^ {f[6], 64'd0};
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ai.s129_in = r[128:0]; ai.s129_out = r[128:0] ^ {f[7], 128'd0};
    h_out[slot] = ai.accum_out;
    h_in[slot]  = inc;
    h_pm[slot]  = {ai.s129_out != ai.s129_in, ai.s65_out != ai.s65_in, ai.s64_out != ai.s64_in,
                   ai.s33_out != ai.s33_in, ai.s8_out != ai.s8_in, ai.s2_out != ai.s2_in,
                   ai.s1_out != ai.s1_in, 1'b0};
  endtask

  task automatic run_test(input bit hold, input bit rinc, input bit povr, input logic [31:0] pacc,
                          input logic [31:0] pinc, input bit chk_prime);
    busy_a = 0; busy_b = 0; rand_inc = rinc;
    tick; ai.start = 1'b1;
    tick; if (!hold) ai.start = 1'b0;
    if (chk_prime) begin
      chk("prime.err", 32'(ai.err_count), 32'd0);
      chk("prime.busy", 32'(ai.busy), 32'd1);
      chk("prime.done", 32'(ai.done), 32'd0);
    end
    if (povr) begin
      acc_nxt = pacc;
      drive(0, 8'h00, pinc);
    end else begin
      drive(0, 8'h00, next_inc());
    end
    for (int k = 0; k < 10; k++) begin
      tick; drive(k + 1, fmask[k], next_inc());
    end
    tick; ai.start = 1'b0;
  endtask

  // Reference: a RUN cycle fails when any tapped pair differs or the accumulator broke out+in.
  task automatic check_model(input string tag);
    logic [7:0] m;
    int ca, cb, bb;
    logic [15:0] fca, fcb;
    logic [7:0] fma, fmb;
    bit stopped;
    ca = 0; cb = 0; bb = 11; fca = 0; fcb = 0; fma = 0; fmb = 0; stopped = 0;
    for (int k = 0; k < 10; k++) begin
      m = h_pm[k + 1];
      m[0] = (h_out[k + 1] != h_out[k] + h_in[k]);
      if (m != 8'h00) begin
        ca++;
        if (ca == 1) begin fca = 16'(k); fma = m; end
        if (!stopped) begin
          cb++;
          if (cb == 1) begin fcb = 16'(k); fmb = m; end
          if (cb == 2) begin stopped = 1; bb = k + 2; end
        end
      end
    end
    chk_out($sformatf("%s.a", tag), 0, 1'b1, 1'b0, ca == 0, 16'(ca), fca, fma);
    chk_out($sformatf("%s.b", tag), 1, 1'b1, 1'b0, cb == 0, 16'(cb), fcb, fmb);
    chk($sformatf("%s.busy_a", tag), 32'(busy_a), 32'd11);
    chk($sformatf("%s.busy_b", tag), 32'(busy_b), 32'(bb));
  endtask

  task automatic clear_faults;
    for (int k = 0; k < 10; k++) fmask[k] = 8'h00;
  endtask

  initial begin
    tbl[0] = '{fcyc: 0, flen: 0,  fm: 8'h00, ea: 0,  fca: 0, fma: 8'h00, eb: 0, fcb: 0, fmb: 8'h00, bbb: 11};
    tbl[1] = '{fcyc: 3, flen: 1,  fm: 8'h40, ea: 1,  fca: 3, fma: 8'h40, eb: 1, fcb: 3, fmb: 8'h40, bbb: 11};
    tbl[2] = '{fcyc: 0, flen: 10, fm: 8'h02, ea: 10, fca: 0, fma: 8'h02, eb: 2, fcb: 0, fmb: 8'h02, bbb: 3};
    tbl[3] = '{fcyc: 9, flen: 1,  fm: 8'h01, ea: 1,  fca: 9, fma: 8'h01, eb: 1, fcb: 9, fmb: 8'h01, bbb: 11};
    tbl[4] = '{fcyc: 0, flen: 2,  fm: 8'h84, ea: 2,  fca: 0, fma: 8'h84, eb: 2, fcb: 0, fmb: 8'h84, bbb: 3};

    rst = 1'b1; ai.start = 1'b0; rand_inc = 0; busy_a = 0; busy_b = 0;
    clear_faults();
    drive(0, 8'h00, 32'd1);
    tick; tick;
    rst = 1'b0;
    chk_out("reset.a", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'h00);
    chk_out("reset.b", 1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'h00);

    for (int v = 0; v < 5; v++) begin
      clear_faults();
      for (int k = tbl[v].fcyc; k < tbl[v].fcyc + tbl[v].flen; k++) fmask[k] = tbl[v].fm;
      run_test(0, 0, 0, 32'd0, 32'd0, 0);
      chk_out($sformatf("vec%0d.a", v), 0, 1'b1, 1'b0, tbl[v].ea == 0, tbl[v].ea, tbl[v].fca, tbl[v].fma);
      chk_out($sformatf("vec%0d.b", v), 1, 1'b1, 1'b0, tbl[v].eb == 0, tbl[v].eb, tbl[v].fcb, tbl[v].fmb);
      chk($sformatf("vec%0d.busy_a", v), 32'(busy_a), 32'd11);
      chk($sformatf("vec%0d.busy_b", v), 32'(busy_b), 32'(tbl[v].bbb));
    end

    // Accumulator wrap-around: FFFF_FFFE + 3 must read back as 1.
    clear_faults();
    run_test(0, 0, 1, 32'hFFFF_FFFE, 32'd3, 0);
    chk_out("wrap_ok", 0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'h00);
    fmask[0] = 8'h01;
    run_test(0, 0, 1, 32'hFFFF_FFFE, 32'd3, 0);
    chk_out("wrap_bad", 0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 8'h01);

    // Reset in the middle of RUN, one error already counted.
    clear_faults();
    fmask[2] = 8'h08;
    tick; ai.start = 1'b1;
    tick; ai.start = 1'b0; drive(0, 8'h00, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick; drive(k + 1, fmask[k], 32'd1);
    end
    tick;
    chk("pre_rst.err", 32'(ai.err_count), 32'd1);
    rst = 1'b1; drive(6, 8'h00, 32'd1);
    tick;
    rst = 1'b0;
    chk_out("mid_rst.a", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'h00);
    chk_out("mid_rst.b", 1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'h00);
    clear_faults();
    run_test(0, 1, 0, 32'd0, 32'd0, 0);
    chk_out("after_rst", 0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'h00);
    chk("after_rst.busy_a", 32'(busy_a), 32'd11);

    // start held high through the whole run must not restart it.
    run_test(1, 1, 0, 32'd0, 32'd0, 0);
    chk_out("hold", 0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'h00);
    chk("hold.busy_a", 32'(busy_a), 32'd11);
    tick;
    chk("hold.no_retrig", 32'(ai.done), 32'd1);

    // Three errors, then a restart from DONE clears everything.
    clear_faults();
    fmask[1] = 8'h08; fmask[4] = 8'h08; fmask[7] = 8'h08;
    run_test(0, 1, 0, 32'd0, 32'd0, 0);
    chk_out("three_err", 0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1, 8'h08);
    check_model("three_err.m");
    clear_faults();
    run_test(0, 1, 0, 32'd0, 32'd0, 1);
    chk_out("restart", 0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'h00);
    chk("restart.busy_a", 32'(busy_a), 32'd11);

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 10; k++)
        fmask[k] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_test(0, 1, 0, 32'd0, 32'd0, 0);
      check_model($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secret_checker.md
Name: secret_checker

Overview:
- Downstream self-checking stage for the secret accumulator/passthrough block. Sits directly on that block's outputs, taps its inputs as well, and checks every cycle.
- Checks the 32-bit accumulator's cycle-to-cycle arithmetic (robust to the accumulator's reset-free power-up value).
- Checks that each passthrough output equals its input.
- Reports pass/fail, error count, and a first-failure record after a programmed number of cycles.

Parameters:
- CYCLES, 100: number of RUN cycles checked per test (1..65535).
- MAX_ERR, 0: early-stop threshold on err_count; 0 = never stop early.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin test; honoured only in IDLE or DONE
- accum_in  input  32  copy of accumulator increment driven to the upstream block
- accum_out  input  32  accumulator value from the upstream block
- s1_in/s1_out  input  1 each  passthrough pair
- s2_in/s2_out  input  2 each  passthrough pair
- s8_in/s8_out  input  8 each  passthrough pair
- s33_in/s33_out  input  33 each  passthrough pair
- s64_in/s64_out  input  64 each  passthrough pair
- s65_in/s65_out  input  65 each  passthrough pair
- s129_in/s129_out  input  129 each  passthrough pair
- busy  output  1  high in PRIME and RUN
- done  output  1  high in DONE
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  16  count of RUN cycles with at least one mismatch; saturates at 0xFFFF
- first_err_cycle  output  16  RUN cycle index (0-based) of first failing cycle
- first_err_mask  output  8  field mismatch bits of first failing cycle: b0 accum, b1 s1, b2 s2, b3 s8, b4 s33, b5 s64, b6 s65, b7 s129

Behaviour:
- State machine: IDLE, PRIME, RUN, DONE. All outputs are registered.
- Reset: on any clk edge with rst=1, go to IDLE. busy, done, pass, err_count, first_err_cycle and first_err_mask all become 0. This applies in every state, including mid-RUN. rst has priority over start.
- IDLE → PRIME on start=1.
- DONE → PRIME on start=1; err_count, first_err_*, cyc and pass are cleared on that same edge.
- PRIME: lasts one cycle.
  - Captures prev_out<=accum_out and prev_in<=accum_in.
  - Performs no checks.
  - Sets cyc<=0, then goes to RUN.
- RUN, on each posedge:
  - mask[0] = (accum_out != prev_out + prev_in), mod 2^32; wrap-around is legal.
  - mask[7:1] = per-field (sN_out != sN_in), sampled at this edge.
  - Update prev_out and prev_in.
  - If mask != 0:
    - err_count increments (saturating).
    - If this is the first error, latch first_err_cycle<=cyc and first_err_mask<=mask.
  - cyc increments.
- RUN → DONE when cyc==CYCLES-1 (checked on this edge, last check included).
- RUN → DONE early when MAX_ERR!=0 and the incremented err_count equals MAX_ERR.
- DONE: done=1, pass=(err_count==0), busy=0. Holds until start or rst.
- start while busy is ignored. start held high through DONE re-triggers PRIME on the first DONE cycle.
- Latency: busy rises the edge after start is sampled. Total busy time = CYCLES+1 cycles when there is no early stop. done rises the edge after the last RUN check.
- first_err_* are held once latched and never overwritten within a test.

Test Plan:
- Fault-free upstream block, CYCLES=10, accum_in=1 constant, start pulse → busy high for exactly 11 cycles, then done=1, pass=1, err_count=0, first_err_mask=0.
- Force s65_out[64] inverted during RUN cycle 3 only → done after 10 checks, pass=0, err_count=1, first_err_cycle=3, first_err_mask=8'h40.
- Accumulator wrap: prev_out=32'hFFFF_FFFE, prev_in=3, accum_out=32'h0000_0001 → no error.
- Same wrap case with accum_out=32'h0000_0002 → mask b0 set, err_count=1.
- MAX_ERR=2, s1_out stuck at ~s1_in from RUN cycle 0 → DONE after RUN cycle 1, err_count=2, first_err_cycle=0, first_err_mask=8'h02.
- rst=1 for one cycle at RUN cycle 5 → next cycle IDLE and all outputs 0; a new start then gives a clean run with pass=1.
- start held high through RUN → no restart; in DONE with err_count=3, start → PRIME, err_count cleared to 0, full new run.
